// File: rtl/i2s_playback_serializer_pkg.sv
// Shared types and constants for the I2S playback serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2s_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        RUN       = 2'd2
    } state_e;

    localparam int DEFAULT_DATA_W = 24;
    localparam int UNDERRUN_CNT_W = 16;

endpackage

// File: rtl/i2s_playback_serializer_if.sv
// Stereo PCM frame stream, {left, right} with left in the upper half.
// Latency: n/a (wiring only).
// Backpressure: valid/ready; a frame moves when s_valid && s_ready.
interface i2s_playback_serializer_if #(
    parameter int DATA_W = 24
);
    logic [2*DATA_W-1:0] s_data;
    logic                s_valid;
    logic                s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/i2s_playback_serializer_fifo.sv
// Generic synchronous FIFO; rdata shows the head entry so a pop consumes it.
// Latency: push visible at the head one clk after the write edge.
// Backpressure: push ignored while full, pop ignored while empty.
module i2s_sample_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW:0]                 wptr_q, wptr_d;
    logic [AW:0]                 rptr_q, rptr_d;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign level = wptr_q - rptr_q;
    assign rdata = mem_q[rptr_q[AW-1:0]];

    // Next-state for storage and pointers; push and pop may coincide.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push && !full) begin
            mem_d[wptr_q[AW-1:0]] = wdata;
            wptr_d                = wptr_q + 1'b1;
        end
        if (pop && !empty) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    // State register; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

endmodule

// File: rtl/i2s_playback_serializer.sv
// Buffers stereo frames and shifts them out as standard I2S (MSB one bclk after lrclk edge).
// Latency: bclk pad fall to dout change is 4 clk; optional I2S_PLAYBACK_UNDERRUN_REPEAT_EN replays the last frame on underrun.
// Backpressure: s_ready = !fifo_full; underrun plays zeros (or repeats) and is counted.
module i2s_playback_serializer
    import i2s_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    i2s_playback_serializer_if.slave      s_if,
    input  logic                          bclk,
    input  logic                          lrclk,
    output logic                          dout,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [UNDERRUN_CNT_W-1:0]     underrun_count,
    input  logic                          underrun_clear,
    output logic                          active
);
    // [0],[1] synchronizer, [2] history
    logic [2:0]                bclk_pipe_q, bclk_pipe_d;
    logic [2:0]                lr_pipe_q, lr_pipe_d;
    logic                      bclk_fall_q, bclk_fall_d;
    logic                      lr_prev_q, lr_prev_d;
    state_e                    state_q, state_d;
    logic [DATA_W-1:0]         shreg_q, shreg_d;
    logic [DATA_W-1:0]         hold_l_q, hold_l_d;
    logic [DATA_W-1:0]         hold_r_q, hold_r_d;
    logic                      dout_q, dout_d;
    logic [UNDERRUN_CNT_W-1:0] ucnt_q, ucnt_d;

    logic                      lr_cur, left_start, right_start, frame_start;
    logic                      fifo_pop, fifo_full, fifo_empty, underrun;
    logic [2*DATA_W-1:0]       fifo_rdata;

    i2s_sample_fifo #(.WIDTH(2*DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (s_if.s_valid && !fifo_full),
        .wdata (s_if.s_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign s_if.s_ready   = !fifo_full;
    assign dout           = dout_q;
    assign underrun_count = ucnt_q;
    assign active         = (state_q == RUN);
    assign lr_cur         = lr_pipe_q[2];

    // Pad synchronizers and a registered bclk falling-edge strobe.
    always_comb begin
        bclk_pipe_d = {bclk_pipe_q[1:0], bclk};
        lr_pipe_d   = {lr_pipe_q[1:0], lrclk};
        bclk_fall_d = bclk_pipe_q[2] && !bclk_pipe_q[1];
    end

    // Slot tracking, FSM, frame fetch, shifter and underrun counter.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        dout_d      = dout_q;
        lr_prev_d   = lr_prev_q;
        ucnt_d      = ucnt_q;
        frame_start = 1'b0;
        fifo_pop    = 1'b0;
        underrun    = 1'b0;

        left_start  = bclk_fall_q && lr_prev_q && !lr_cur;
        right_start = bclk_fall_q && !lr_prev_q && lr_cur;
        if (bclk_fall_q) begin
            lr_prev_d = lr_cur;
        end

        if (!enable) begin
            state_d  = IDLE;
            dout_d   = 1'b0;
            shreg_d  = '0;
            hold_l_d = '0;
            hold_r_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    dout_d  = 1'b0;
                    state_d = WAIT_SYNC;
                end
                WAIT_SYNC: begin
                    dout_d = 1'b0;
                    if (left_start) begin
                        state_d     = RUN;
                        frame_start = 1'b1;
                    end
                end
                RUN: begin
                    // Slot-start edges only load; the MSB goes out on the following fall.
                    if (left_start) begin
                        frame_start = 1'b1;
                    end else if (right_start) begin
                        shreg_d = hold_r_q;
                    end else if (bclk_fall_q) begin
                        dout_d  = shreg_q[DATA_W-1];
                        shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                    end
                end
                default: begin
                    state_d = IDLE;
                    dout_d  = 1'b0;
                end
            endcase
        end

        if (frame_start) begin
            if (fifo_empty) begin
                underrun = 1'b1;
`ifdef I2S_PLAYBACK_UNDERRUN_REPEAT_EN
                shreg_d  = hold_l_q;
`else
                hold_l_d = '0;
                hold_r_d = '0;
                shreg_d  = '0;
`endif
            end else begin
                fifo_pop = 1'b1;
                hold_l_d = fifo_rdata[2*DATA_W-1 -: DATA_W];
                hold_r_d = fifo_rdata[DATA_W-1:0];
                shreg_d  = fifo_rdata[2*DATA_W-1 -: DATA_W];
            end
        end

        // Clear wins over a same-cycle increment; count saturates.
        if (underrun_clear) begin
            ucnt_d = '0;
        end else if (underrun && (ucnt_q != '1)) begin
            ucnt_d = ucnt_q + 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_pipe_q <= '0;
            lr_pipe_q   <= '0;
            bclk_fall_q <= 1'b0;
            lr_prev_q   <= 1'b0;
            state_q     <= IDLE;
            shreg_q     <= '0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            dout_q      <= 1'b0;
            ucnt_q      <= '0;
        end else begin
            bclk_pipe_q <= bclk_pipe_d;
            lr_pipe_q   <= lr_pipe_d;
            bclk_fall_q <= bclk_fall_d;
            lr_prev_q   <= lr_prev_d;
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            dout_q      <= dout_d;
            ucnt_q      <= ucnt_d;
        end
    end

endmodule

// File: tb/tb_i2s_playback_serializer.sv
// Directed bench for the I2S playback serializer, DATA_W=24, FIFO_DEPTH=8, bclk = clk/16.
// Latency: captures each bit 6 clk after the bclk pad fall; probes the 4-clk pad-to-dout path.
// Backpressure: exercises FIFO full, simultaneous push/pop, underrun, disable and short slots.
module tb_i2s_playback_serializer;

    localparam int DW = 24;
`ifdef I2S_PLAYBACK_UNDERRUN_REPEAT_EN
    localparam bit REPEAT = 1'b1;
`else
    localparam bit REPEAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, enable, bclk, lrclk, underrun_clear;
    logic        dout, active;
    logic [3:0]  fifo_level;
    logic [15:0] underrun_count;

    int          checks   = 0;
    int          failures = 0;
    int          probe_j  = -1;
    logic        lat3, lat4;
    logic [31:0] lc, rc;

    i2s_playback_serializer_if #(.DATA_W(DW)) s_if ();

    i2s_playback_serializer #(.DATA_W(DW), .FIFO_DEPTH(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .s_if           (s_if.slave),
        .bclk           (bclk),
        .lrclk          (lrclk),
        .dout           (dout),
        .fifo_level     (fifo_level),
        .underrun_count (underrun_count),
        .underrun_clear (underrun_clear),
        .active         (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected slot capture (bits 1..slot-1, MSB first): zero pad or LSB truncation.
    function automatic logic [31:0] exp_slot(input logic [23:0] data, input int slot);
        logic [31:0] d;
        int          nb;
        d  = {8'h00, data};
        nb = slot - 1;
        if (nb >= DW) return d << (nb - DW);
        return d >> (DW - nb);
    endfunction

    function automatic logic [23:0] l_of(input int k);
        return 24'h800000 + 24'(k * 24'h013579);
    endfunction

    function automatic logic [23:0] r_of(input int k);
        return 24'h2468AC ^ 24'(k * 24'h010203);
    endfunction

    // One bclk period: fall at N0 (lrclk changes with it), rise at N8.
    task automatic bclk_cycle(input logic lr, input int j, output logic b);
        @(negedge clk); bclk = 1'b0; lrclk = lr;
        repeat (3) @(negedge clk);
        if (j == probe_j) lat3 = dout;
        @(negedge clk);
        if (j == probe_j) lat4 = dout;
        repeat (2) @(negedge clk);
        b = dout;
        repeat (2) @(negedge clk);
        bclk = 1'b1;
        repeat (7) @(negedge clk);
    endtask

    task automatic play_range(input logic lr, input int j0, input int j1, output logic [31:0] cap);
        logic b;
        cap = '0;
        for (int j = j0; j < j1; j++) begin
            bclk_cycle(lr, j, b);
            if (j > 0) cap = {cap[30:0], b};
        end
    endtask

    task automatic play_frame(input int slot, output logic [31:0] l, output logic [31:0] r);
        play_range(1'b0, 0, slot, l);
        play_range(1'b1, 0, slot, r);
    endtask

    task automatic push(input logic [47:0] f);
        @(negedge clk); s_if.s_data = f; s_if.s_valid = 1'b1;
        @(negedge clk); s_if.s_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; bclk = 1'b1; lrclk = 1'b1; underrun_clear = 1'b0;
        s_if.s_valid = 1'b0; s_if.s_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_ready", 32'(s_if.s_ready), 32'd1);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ucnt", 32'(underrun_count), 32'd0);
        check("rst_active", 32'(active), 32'd0);

        // Basic frame
        push({24'hA5A5A5, 24'h3C3C3C});
        check("basic_level1", 32'(fifo_level), 32'd1);
        enable = 1'b1;
        play_range(1'b1, 0, 32, rc);
        check("wait_sync_active", 32'(active), 32'd0);
        check("wait_sync_dout", 32'(dout), 32'd0);
        probe_j = 1;
        play_range(1'b0, 0, 32, lc);
        check("basic_left", lc, exp_slot(24'hA5A5A5, 32));
        check("basic_lat3_left", 32'(lat3), 32'd0);
        check("basic_lat4_left", 32'(lat4), 32'd1);
        check("basic_active", 32'(active), 32'd1);
        check("basic_level0", 32'(fifo_level), 32'd0);
        probe_j = 3;
        play_range(1'b1, 0, 32, rc);
        check("basic_right", rc, exp_slot(24'h3C3C3C, 32));
        check("basic_lat3_right", 32'(lat3), 32'd0);
        check("basic_lat4_right", 32'(lat4), 32'd1);
        probe_j = -1;

        // Underrun: three frames from an empty FIFO
        for (int f = 0; f < 3; f++) begin
            play_frame(32, lc, rc);
            check("underrun_left", lc, REPEAT ? exp_slot(24'hA5A5A5, 32) : 32'd0);
            check("underrun_right", rc, REPEAT ? exp_slot(24'h3C3C3C, 32) : 32'd0);
        end
        check("underrun_cnt3", 32'(underrun_count), 32'd3);
        @(negedge clk); underrun_clear = 1'b1;
        @(negedge clk); underrun_clear = 1'b0;
        check("underrun_clear", 32'(underrun_count), 32'd0);

        // One frame then two underruns (replay or zeros)
        push({24'h123456, 24'h654321});
        play_frame(32, lc, rc);
        check("rep_first_left", lc, exp_slot(24'h123456, 32));
        check("rep_first_right", rc, exp_slot(24'h654321, 32));
        for (int f = 0; f < 2; f++) begin
            play_frame(32, lc, rc);
            check("rep_left", lc, REPEAT ? exp_slot(24'h123456, 32) : 32'd0);
            check("rep_right", rc, REPEAT ? exp_slot(24'h654321, 32) : 32'd0);
        end
        check("rep_ucnt2", 32'(underrun_count), 32'd2);

        // FIFO full with bclk static: 9th frame held off
        @(negedge clk); s_if.s_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            s_if.s_data = {l_of(k), r_of(k)};
            @(negedge clk);
        end
        check("full_ready", 32'(s_if.s_ready), 32'd0);
        check("full_level", 32'(fifo_level), 32'd8);
        repeat (20) @(negedge clk);
        check("full_level_hold", 32'(fifo_level), 32'd8);
        // Left start pops frame 0; the held 9th frame goes in one clk later.
        @(negedge clk); bclk = 1'b0; lrclk = 1'b0;
        repeat (4) @(negedge clk);
        check("full_pop_level", 32'(fifo_level), 32'd7);
        check("full_pop_ready", 32'(s_if.s_ready), 32'd1);
        @(negedge clk);
        check("full_refill_level", 32'(fifo_level), 32'd8);
        s_if.s_valid = 1'b0;
        repeat (3) @(negedge clk); bclk = 1'b1;
        repeat (7) @(negedge clk);
        play_range(1'b0, 1, 32, lc);
        check("f0_left", lc, exp_slot(l_of(0), 32));
        play_range(1'b1, 0, 32, rc);
        check("f0_right", rc, exp_slot(r_of(0), 32));
        for (int k = 1; k <= 4; k++) begin
            play_frame(32, lc, rc);
            check("fk_left", lc, exp_slot(l_of(k), 32));
            check("fk_right", rc, exp_slot(r_of(k), 32));
        end

        // Push on the exact clk of a left-start pop
        @(negedge clk); bclk = 1'b0; lrclk = 1'b0;
        repeat (3) @(negedge clk);
        check("pp_level_before", 32'(fifo_level), 32'd4);
        s_if.s_data = {l_of(9), r_of(9)}; s_if.s_valid = 1'b1;
        @(negedge clk);
        s_if.s_valid = 1'b0;
        check("pp_level_after", 32'(fifo_level), 32'd4);
        repeat (3) @(negedge clk); bclk = 1'b1;
        repeat (7) @(negedge clk);
        play_range(1'b0, 1, 32, lc);
        check("f5_left", lc, exp_slot(l_of(5), 32));
        play_range(1'b1, 0, 32, rc);
        check("f5_right", rc, exp_slot(r_of(5), 32));
        for (int k = 6; k <= 9; k++) begin
            play_frame(32, lc, rc);
            check("order_left", lc, exp_slot(l_of(k), 32));
            check("order_right", rc, exp_slot(r_of(k), 32));
        end
        check("drained_level", 32'(fifo_level), 32'd0);

        // Disable mid-frame, then resume at the next left start
        push({24'hFFFFFF, 24'h000001});
        push({24'h5A5A5A, 24'h0F0F0F});
        play_range(1'b0, 0, 10, lc);
        check("dis_bits1to9", lc, 32'h1FF);
        check("dis_dout_before", 32'(dout), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        check("dis_dout", 32'(dout), 32'd0);
        check("dis_active", 32'(active), 32'd0);
        check("dis_level", 32'(fifo_level), 32'd1);
        repeat (2) @(negedge clk);
        enable = 1'b1;
        play_range(1'b0, 10, 32, lc);
        check("dis_rest_left", lc, 32'd0);
        play_range(1'b1, 0, 32, rc);
        check("dis_right", rc, 32'd0);
        check("dis_wait_active", 32'(active), 32'd0);
        play_frame(32, lc, rc);
        check("resume_left", lc, exp_slot(24'h5A5A5A, 32));
        check("resume_right", rc, exp_slot(24'h0F0F0F, 32));
        check("resume_active", 32'(active), 32'd1);

        // Short 16-bit slots truncate LSBs
        push({24'hFFFF00, 24'hABCDEF});
        push({24'h123456, 24'h789ABC});
        play_frame(16, lc, rc);
        check("short_left", lc, 32'h7FFF);
        check("short_right", rc, exp_slot(24'hABCDEF, 16));
        play_frame(16, lc, rc);
        check("short2_left", lc, exp_slot(24'h123456, 16));
        check("short2_right", rc, exp_slot(24'h789ABC, 16));
        check("final_ucnt", 32'(underrun_count), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
